// File: rtl/cpu_run_ctrl_if.sv
// Console-side command/status bundle between the debug VIO and the run controller.
// The controller takes the slave view; the console/CPU side takes the master view.
interface cpu_run_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             cmd_step;
  logic             cmd_run;
  logic             cmd_runn;
  logic             cmd_halt;
  logic [CNT_W-1:0] run_count;
  logic             bp_en;
  logic [31:0]      bp_addr;
  logic [31:0]      pc;
  logic             cpu_en;
  logic             halted;
  logic [1:0]       state;
  logic             bp_hit;
  logic [31:0]      cycles;

  modport master (
    output cmd_step, cmd_run, cmd_runn, cmd_halt, run_count, bp_en, bp_addr, pc,
    input  cpu_en, halted, state, bp_hit, cycles
  );

  modport slave (
    input  cmd_step, cmd_run, cmd_runn, cmd_halt, run_count, bp_en, bp_addr, pc,
    output cpu_en, halted, state, bp_hit, cycles
  );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/step controller: synchronises VIO command levels into one-cycle pulses and
// sequences the CPU clock enable for halt, step, free run, run-N and PC breakpoint.
module cpu_run_ctrl #(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic           clk,
  input  logic           reset,
  cpu_run_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_HALT = 2'd0,
    ST_STEP = 2'd1,
    ST_RUN  = 2'd2,
    ST_RUNN = 2'd3
  } state_t;

  // Command bit order: 0=step, 1=run, 2=runn, 3=halt
  logic [3:0] cmd_raw;
  logic [3:0] cmd_sync;
  logic [3:0] cmd_prev_reg;
  logic [3:0] pulse;

  assign cmd_raw = {bus.cmd_halt, bus.cmd_runn, bus.cmd_run, bus.cmd_step};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      logic [SYNC_STAGES-1:0] sync_reg;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) sync_reg <= '0;
        else        sync_reg <= {sync_reg[SYNC_STAGES-2:0], cmd_raw[gi]};
      end
      assign cmd_sync[gi] = sync_reg[SYNC_STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) cmd_prev_reg <= '0;
    else        cmd_prev_reg <= cmd_sync;
  end

  assign pulse = cmd_sync & ~cmd_prev_reg;

  logic step_p, run_p, runn_p, halt_p;
  assign step_p = pulse[0];
  assign run_p  = pulse[1];
  assign runn_p = pulse[2];
  assign halt_p = pulse[3];

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             bp_hit_reg, bp_hit_next;
  logic [31:0]      cycles_reg;
  logic             cpu_en_c;
  logic             bp_match;

  assign bp_match = bus.bp_en && (bus.pc == bus.bp_addr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= ST_HALT;
      cnt_reg    <= '0;
      bp_hit_reg <= 1'b0;
      cycles_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      bp_hit_reg <= bp_hit_next;
      cycles_reg <= cycles_reg + {31'd0, cpu_en_c};
    end
  end

  // Enable is the state decode gated by the stop terms seen this very cycle,
  // so a breakpoint PC or a halt never commits an instruction.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    bp_hit_next = bp_hit_reg;
    cpu_en_c    = 1'b0;
    case (state_reg)
      ST_HALT: begin
        if (halt_p) begin
          state_next = ST_HALT;
        end else if (step_p) begin
          state_next  = ST_STEP;
          bp_hit_next = 1'b0;
        end else if (runn_p) begin
          bp_hit_next = 1'b0;
          if (bus.run_count != '0) begin
            state_next = ST_RUNN;
            cnt_next   = bus.run_count;
          end
        end else if (run_p) begin
          state_next  = ST_RUN;
          bp_hit_next = 1'b0;
        end
      end
      ST_STEP: begin
        cpu_en_c   = 1'b1;
        state_next = ST_HALT;
      end
      ST_RUN, ST_RUNN: begin
        if (halt_p || bp_match) begin
          state_next  = ST_HALT;
          cnt_next    = '0;
          bp_hit_next = bp_hit_reg | bp_match;
        end else begin
          cpu_en_c = 1'b1;
          if (state_reg == ST_RUNN) begin
            cnt_next = cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) state_next = ST_HALT;
          end
        end
      end
      default: state_next = ST_HALT;
    endcase
  end

  assign bus.cpu_en = cpu_en_c;
  assign bus.halted = (state_reg == ST_HALT);
  assign bus.state  = state_reg;
  assign bus.bp_hit = bp_hit_reg;
  assign bus.cycles = cycles_reg;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: a command vector table plus hand sequences for
// halt timing, coincident commands, breakpoint stop/step-off and async reset.
module tb_cpu_run_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  cpu_run_ctrl_if #(.CNT_W(16)) bus ();

  cpu_run_ctrl #(.CNT_W(16), .SYNC_STAGES(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Simple CPU model: PC advances by one word per enabled cycle
  always @(posedge clk or negedge reset) begin
    if (!reset)          bus.pc <= 32'd0;
    else if (bus.cpu_en) bus.pc <= bus.pc + 32'd4;
  end

  // Independent observation of cpu_en, sampled away from the active edge
  int en_total   = 0;
  int rise_total = 0;
  logic en_prev  = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      en_total   = 0;
      rise_total = 0;
      en_prev    = 1'b0;
    end else begin
      if (bus.cpu_en) en_total = en_total + 1;
      if (bus.cpu_en && !en_prev) rise_total = rise_total + 1;
      en_prev = bus.cpu_en;
    end
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic [3:0] c);
    bus.cmd_step = c[0];
    bus.cmd_run  = c[1];
    bus.cmd_runn = c[2];
    bus.cmd_halt = c[3];
  endtask

  typedef struct {
    string       name;
    logic [3:0]  cmd;       // {halt, runn, run, step}
    logic [15:0] rc;
    int          hold;
    int          exp_en;    // -1: enable count not fixed for this vector
    int          exp_rises;
    logic [1:0]  exp_state;
    logic        exp_bp;
  } vec_t;

  task automatic apply_vec(input vec_t v);
    int s_en, s_r;
    s_en = en_total;
    s_r  = rise_total;
    bus.run_count = v.rc;
    set_cmd(v.cmd);
    repeat (v.hold) tick();
    set_cmd(4'b0000);
    repeat (12) tick();
    if (v.exp_en >= 0) begin
      check({v.name, " en_count"}, 32'(en_total - s_en), 32'(v.exp_en));
      check({v.name, " en_rises"}, 32'(rise_total - s_r), 32'(v.exp_rises));
    end
    check({v.name, " state"},  32'(bus.state),  32'(v.exp_state));
    check({v.name, " halted"}, 32'(bus.halted), 32'(v.exp_state == 2'd0));
    check({v.name, " bp_hit"}, 32'(bus.bp_hit), 32'(v.exp_bp));
    $display("vec %s: cmd=%b rc=%0d en=%0d state=%0d bp_hit=%0b cycles=%0d",
             v.name, v.cmd, v.rc, en_total - s_en, bus.state, bus.bp_hit, bus.cycles);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (3) tick();
  endtask

  vec_t vecs[8];

  initial begin
    int s_en;
    vecs[0] = '{"step1",  4'b0001, 16'd0,    10,  1, 1, 2'd0, 1'b0};
    vecs[1] = '{"step2",  4'b0001, 16'd0,    10,  1, 1, 2'd0, 1'b0};
    vecs[2] = '{"step3",  4'b0001, 16'd0,    10,  1, 1, 2'd0, 1'b0};
    vecs[3] = '{"runn5",  4'b0100, 16'd5,    10,  5, 1, 2'd0, 1'b0};
    vecs[4] = '{"runn0",  4'b0100, 16'd0,    10,  0, 0, 2'd0, 1'b0};
    vecs[5] = '{"halt0",  4'b1000, 16'd0,    10,  0, 0, 2'd0, 1'b0};
    vecs[6] = '{"run100", 4'b0010, 16'd0,   100, -1, 1, 2'd2, 1'b0};
    vecs[7] = '{"halt",   4'b1000, 16'd0,    10, -1, 0, 2'd0, 1'b0};

    set_cmd(4'b0000);
    bus.run_count = 16'd0;
    bus.bp_en     = 1'b0;
    bus.bp_addr   = 32'd0;
    #2;
    check("async reset cpu_en", 32'(bus.cpu_en), 32'd0);
    repeat (2) tick();
    check("reset state",  32'(bus.state),  32'd0);
    check("reset halted", 32'(bus.halted), 32'd1);
    check("reset bp_hit", 32'(bus.bp_hit), 32'd0);
    check("reset cycles", bus.cycles,      32'd0);
    reset = 1'b1;
    repeat (3) tick();

    for (int i = 0; i < 8; i++) begin
      apply_vec(vecs[i]);
      if (i == 2) check("cycles after 3 steps", bus.cycles, 32'd3);
      if (i == 3) check("cycles after runn5",   bus.cycles, 32'd8);
    end
    check("cycles vs observed", bus.cycles, 32'(en_total));

    // Run, stray step mid-run (ignored), halt 20 cycles after the run edge
    s_en = en_total;
    bus.cmd_run = 1'b1;
    repeat (10) tick();
    bus.cmd_step = 1'b1;
    repeat (10) tick();
    bus.cmd_run  = 1'b0;
    bus.cmd_step = 1'b0;
    bus.cmd_halt = 1'b1;
    repeat (20) tick();
    bus.cmd_halt = 1'b0;
    repeat (5) tick();
    check("run-halt en_count", 32'(en_total - s_en), 32'd19);
    check("run-halt state",    32'(bus.state),       32'd0);
    check("run-halt bp_hit",   32'(bus.bp_hit),      32'd0);
    check("run-halt cycles",   bus.cycles,           32'(en_total));
    $display("seq run-halt: en=%0d state=%0d cycles=%0d", en_total - s_en, bus.state, bus.cycles);

    // Halt and run rising together from HALT: halt wins
    s_en = en_total;
    set_cmd(4'b1010);
    repeat (10) tick();
    set_cmd(4'b0000);
    repeat (5) tick();
    check("coincident en_count", 32'(en_total - s_en), 32'd0);
    check("coincident state",    32'(bus.state),       32'd0);
    $display("seq coincident: en=%0d state=%0d", en_total - s_en, bus.state);

    // Breakpoint at 0x10 with PC starting from 0, then step off it
    do_reset();
    bus.bp_en   = 1'b1;
    bus.bp_addr = 32'h10;
    apply_vec('{"bp_run", 4'b0010, 16'd0, 10, 4, 1, 2'd0, 1'b1});
    check("bp pc held", bus.pc, 32'h10);
    apply_vec('{"bp_step", 4'b0001, 16'd0, 10, 1, 1, 2'd0, 1'b0});
    check("bp step pc", bus.pc, 32'h14);
    check("bp cycles",  bus.cycles, 32'd5);
    bus.bp_en = 1'b0;

    // Asynchronous reset in the middle of a long run-N
    bus.run_count = 16'd1000;
    bus.cmd_runn  = 1'b1;
    repeat (20) tick();
    check("runn active", 32'(bus.state), 32'd3);
    reset = 1'b0;
    #2;
    check("mid-run reset cpu_en", 32'(bus.cpu_en), 32'd0);
    check("mid-run reset cycles", bus.cycles,      32'd0);
    check("mid-run reset state",  32'(bus.state),  32'd0);
    bus.cmd_runn = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (20) tick();
    check("post-reset en_count", 32'(en_total), 32'd0);
    check("post-reset state",    32'(bus.state), 32'd0);
    $display("seq mid-run reset: en=%0d state=%0d cycles=%0d", en_total, bus.state, bus.cycles);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish, expected finish before 200000");
    $fatal(1);
  end

endmodule
